// File: rtl/cla_stream_alu_pkg.sv
// Shared encodings and defaults for the chunk-serial carry-look-ahead ALU.
package cla_stream_alu_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  localparam logic [1:0] MODE_ADD = 2'b00;
  localparam logic [1:0] MODE_SUB = 2'b01;
  localparam logic [1:0] MODE_ACC = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_CALC,
    ST_SEND
  } state_t;

endpackage

// File: rtl/carry_look_ahead.sv
// Full-width adder built from per-bit generate/propagate terms.
module carry_look_ahead
  import cla_stream_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             y,
  output logic             c,
  output logic [WIDTH-1:0] s
);

  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   cy;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    cy    = '0;
    cy[0] = y;
    for (int i = 0; i < WIDTH; i++) begin
      cy[i+1] = g[i] | (p[i] & cy[i]);
    end
  end

  assign s = p ^ cy[WIDTH-1:0];
  assign c = cy[WIDTH];

endmodule

// File: rtl/cla_stream_alu.sv
// Chunk-serial add/sub/accumulate unit: operands stream in LSB-first,
// one full-width CLA computes the result, which streams back LSB-first.
//
//   state     | meaning
//   ST_IDLE   | waiting for first beat; latches mode, writes chunk 0
//   ST_LOAD_A | collecting remaining A chunks
//   ST_LOAD_B | collecting B chunks (one fewer in ACC, chunk 0 came in IDLE)
//   ST_CALC   | one cycle: register sum, acc and carry
//   ST_SEND   | streaming result chunks to the consumer
module cla_stream_alu
  import cla_stream_alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [CHUNK-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CHUNK-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             carry,
  output logic             busy
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int IW  = $clog2(NCH);
  localparam logic [IW-1:0] LAST_IDX = IW'(NCH - 1);

  state_t           state, state_nxt;
  logic [IW-1:0]    idx;
  logic [IW-1:0]    wr_pos;
  logic [1:0]       mode;
  logic [WIDTH-1:0] a_reg, b_reg, result, acc;
  logic [WIDTH-1:0] add_a, add_b, sum;
  logic             sum_c;
  logic             sub_op;
  logic             in_fire, out_fire;

  // idx restarts on every state change, so stages that skipped chunk 0
  // write one position ahead of the counter.
  always_comb begin
    wr_pos = idx;
    if (state == ST_LOAD_A || (state == ST_LOAD_B && mode == MODE_ACC))
      wr_pos = idx + 1'b1;
  end

  assign sub_op = (mode == MODE_SUB);
  assign add_a  = (mode == MODE_ACC) ? acc : a_reg;
  assign add_b  = sub_op ? ~b_reg : b_reg;

  carry_look_ahead #(.WIDTH(WIDTH)) u_cla (
    .a (add_a),
    .b (add_b),
    .y (sub_op),
    .c (sum_c),
    .s (sum)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_data  = '0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nxt = (in_mode == MODE_ACC) ? ST_LOAD_B : ST_LOAD_A;
      end
      ST_LOAD_A: begin
        in_ready = 1'b1;
        if (in_valid && wr_pos == LAST_IDX) state_nxt = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        in_ready = 1'b1;
        if (in_valid && wr_pos == LAST_IDX) state_nxt = ST_CALC;
      end
      ST_CALC: state_nxt = ST_SEND;
      ST_SEND: begin
        out_valid = 1'b1;
        out_data  = result[idx*CHUNK +: CHUNK];
        out_last  = (idx == LAST_IDX);
        if (out_ready && out_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy     = (state != ST_IDLE);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      idx    <= '0;
      mode   <= MODE_ADD;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      acc    <= '0;
      carry  <= 1'b0;
    end else begin
      if (state_nxt != state)
        idx <= '0;
      else if (in_fire || out_fire)
        idx <= idx + 1'b1;

      if (state == ST_IDLE && in_fire) begin
        if (in_mode == MODE_SUB || in_mode == MODE_ACC) mode <= in_mode;
        else                                            mode <= MODE_ADD;
      end

      if (in_fire) begin
        if (state == ST_LOAD_A || (state == ST_IDLE && in_mode != MODE_ACC))
          a_reg[wr_pos*CHUNK +: CHUNK] <= in_data;
        else
          b_reg[wr_pos*CHUNK +: CHUNK] <= in_data;
      end

      if (state == ST_CALC) begin
        result <= sum;
        acc    <= sum;
        carry  <= sum_c;
      end
    end
  end

endmodule

// File: tb/tb_cla_stream_alu.sv
// Directed bench for cla_stream_alu at WIDTH=16, CHUNK=4.
module tb_cla_stream_alu;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [3:0] in_data;
  logic [1:0] in_mode;
  logic       in_ready;
  logic       out_valid;
  logic [3:0] out_data;
  logic       out_last;
  logic       out_ready;
  logic       carry;
  logic       busy;

  int n_checks = 0;
  int n_pass   = 0;

  cla_stream_alu #(.WIDTH(16), .CHUNK(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .carry     (carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the beat transfers.
  task automatic put_beat(input logic [3:0] d, input logic [1:0] m);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("in_ready_timeout", 32'(n), 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 4'h0;
  endtask

  task automatic collect(input string tag, input int stall, output logic [15:0] res,
                         output int lat, output int nb);
    int cyc = 0;
    logic [3:0] held;
    res = '0;
    nb = 0;
    lat = -1;
    out_ready = 1'b1;
    while (nb < 4 && cyc < 40) begin
      if (out_valid) begin
        if (lat < 0) lat = cyc;
        chk({tag, "_last"}, 32'(out_last), 32'(nb == 3));
        chk({tag, "_inrdy_send"}, 32'(in_ready), 0);
        if (nb == stall) begin
          out_ready = 1'b0;
          held = out_data;
          repeat (3) begin
            @(negedge clk);
            cyc++;
            chk({tag, "_hold_data"}, 32'(out_data), 32'(held));
            chk({tag, "_hold_valid"}, 32'(out_valid), 1);
          end
          out_ready = 1'b1;
        end
        res[nb*4 +: 4] = out_data;
        nb++;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] a,
                        input logic [15:0] b, input int stall,
                        input logic [15:0] exp_s, input logic exp_c);
    logic [15:0] res;
    int lat, nb;
    chk({tag, "_idle_rdy"}, 32'(in_ready), 1);
    if (m != 2'b10) begin
      for (int i = 0; i < 4; i++) put_beat(a[i*4 +: 4], m);
      repeat (2) @(negedge clk);
    end
    for (int i = 0; i < 4; i++) put_beat(b[i*4 +: 4], m);
    chk({tag, "_calc_busy"}, 32'(busy), 1);
    chk({tag, "_calc_rdy"}, 32'(in_ready), 0);
    chk({tag, "_calc_ov"}, 32'(out_valid), 0);
    collect(tag, stall, res, lat, nb);
    chk({tag, "_beats"}, 32'(nb), 4);
    chk({tag, "_latency"}, 32'(lat), 1);
    chk({tag, "_result"}, 32'(res), 32'(exp_s));
    chk({tag, "_carry"}, 32'(carry), 32'(exp_c));
    chk({tag, "_end_busy"}, 32'(busy), 0);
    chk({tag, "_end_ov"}, 32'(out_valid), 0);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 4'h0;
    in_mode = 2'b00;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_out_last", 32'(out_last), 0);
    chk("rst_carry", 32'(carry), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_in_ready", 32'(in_ready), 1);

    run_op("add1",  2'b00, 16'h1234, 16'h0FFF, -1, 16'h2233, 1'b0);
    run_op("acc1",  2'b10, 16'h0000, 16'h0001, -1, 16'h2234, 1'b0);
    run_op("acc2",  2'b10, 16'h0000, 16'hFFFF, -1, 16'h2233, 1'b1);
    run_op("addw",  2'b00, 16'hFFFF, 16'h0001, -1, 16'h0000, 1'b1);
    run_op("mode3", 2'b11, 16'hFFFF, 16'h0001, -1, 16'h0000, 1'b1);
    run_op("sub1",  2'b01, 16'h0005, 16'h0007, -1, 16'hFFFE, 1'b0);
    run_op("bp",    2'b00, 16'h1234, 16'h0FFF,  1, 16'h2233, 1'b0);
    run_op("sub2",  2'b01, 16'h0007, 16'h0005, -1, 16'h0002, 1'b1);

    for (int i = 0; i < 4; i++) put_beat(4'hA, 2'b00);
    put_beat(4'h5, 2'b00);
    put_beat(4'h5, 2'b00);
    chk("mid_busy", 32'(busy), 1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_ov", 32'(out_valid), 0);
    chk("mid_rst_carry", 32'(carry), 0);
    chk("mid_rst_rdy", 32'(in_ready), 1);
    repeat (3) @(negedge clk);
    chk("mid_rst_quiet", 32'(out_valid), 0);

    run_op("acc3",  2'b10, 16'h0000, 16'h0003, -1, 16'h0003, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cla_stream_alu.md
# cla_stream_alu

Parametrised, sequential successor to the pin-limited carry-look-ahead adder top. Operands arrive LSB-first over a narrow CHUNK-bit handshaked input, are summed or subtracted at full WIDTH by one carry-look-ahead instance, and the result streams back LSB-first over a CHUNK-bit handshaked output. Adds subtract and accumulate modes, plus back-pressure. It sits behind the IO pad wrapper, in place of the clock-edge input mux.

## Interface
- WIDTH, 16: operand/result width; multiple of CHUNK; WIDTH/CHUNK ≥ 2
- CHUNK, 4: beat width in both directions
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input beat offered
- in_data  in  CHUNK  operand chunk, LSB chunk first
- in_mode  in  2  operation; sampled only on the first beat of a transaction
- in_ready  out  1  block accepts a beat this cycle
- out_valid  out  1  result beat offered
- out_data  out  CHUNK  result chunk, LSB chunk first
- out_last  out  1  high with the final result beat
- out_ready  in  1  consumer accepts the beat
- carry  out  1  carry-out of the last operation; held until the next CALC
- busy  out  1  high in any state other than IDLE

## Operation
- NCH = WIDTH/CHUNK. Beat transfer = valid & ready on the same rising edge.
- Modes: 00 ADD (A+B); 01 SUB (A+~B+1, carry=1 means no borrow); 10 ACC (A = acc register, B streamed); 11 treated as ADD.
- FSM states: IDLE, LOAD_A, LOAD_B, CALC, SEND.
  - IDLE: in_ready=1. First accepted beat latches in_mode and writes chunk 0.
    - ACC: chunk 0 goes to B, next state LOAD_B.
    - Otherwise: chunk 0 goes to A, next state LOAD_A.
  - LOAD_A: in_ready=1. Fills A chunks 1..NCH-1, then goes to LOAD_B.
  - LOAD_B: in_ready=1. Fills all NCH chunks of B (NCH-1 remaining in ACC), then goes to CALC.
  - CALC: single cycle, in_ready=0. Registers the adder sum into the result register and acc, and the carry into `carry`.
  - SEND: out_valid=1 and out_data = result chunk[idx]. idx advances on each transfer. out_last=1 when idx=NCH-1; transfer of that beat returns to IDLE.
- Beat index counter: ceil(log2(NCH)) bits, cleared on every state change.
- Adder connections: a=A; b=B (ADD/ACC) or ~B (SUB); carry-in y = 1 for SUB, else 0. Arithmetic wraps modulo 2^WIDTH.
- in_ready=0 in CALC and SEND. No new transaction overlaps output streaming.

## Timing
- Reset: with rst high at an edge, the following are cleared: state=IDLE, A, B, result, acc, idx, mode, carry. After reset: out_valid=0, out_data=0, out_last=0, carry=0, busy=0, in_ready=1 (IDLE). rst wins over any simultaneous transfer.
- Reset mid-transaction: partial operands are discarded and acc is cleared. No output beat appears.
- Latency: the last B beat accepted at edge t puts the block in CALC for cycle t..t+1. out_valid rises after edge t+1. The final beat completes no earlier than edge t+1+NCH.
- Back-pressure: while out_valid=1 and out_ready=0, out_data, out_last and idx are held. No beat is dropped or repeated.
- in_valid low during LOAD_*: the block waits indefinitely with no timeout. in_data is ignored when in_valid=0.
- out_data/out_last are registered or derived from registered state only; no combinational path from in_* to out_*.
- carry changes only at the CALC edge.

## Structure
- Shared package/header holds:
  - mode encodings: MODE_ADD=2'b00, MODE_SUB=2'b01, MODE_ACC=2'b10
  - FSM state encoding
  - default WIDTH/CHUNK
- One sub-module: the existing `carry_look_ahead` (ports a, b, y, c, s), instantiated once at WIDTH.
- Everything else is inline: FSM, chunk write decoders, output mux.

## Test plan
All scenarios use WIDTH=16, CHUNK=4.
- ADD 0x1234+0x0FFF: in beats 4,3,2,1 then F,F,F,0 -> out beats 3,3,2,2 (0x2233), carry=0, out_last on 4th beat.
- ADD 0xFFFF+0x0001 -> out 0x0000, carry=1; mode 11 with the same operands gives an identical result.
- SUB 0x0005−0x0007 -> 0xFFFE, carry=0; SUB 0x0007−0x0005 -> 0x0002, carry=1.
- ACC after the first scenario (acc=0x2233), B=0x0001 (beats 1,0,0,0) -> 0x2234. A second ACC with B=0xFFFF -> 0x2233, carry=1.
- Back-pressure: out_ready low for 3 cycles after beat 1 -> beat 1 held stable, all 4 beats delivered exactly once. in_ready=0 throughout CALC/SEND.
- rst pulse during LOAD_B -> next cycle busy=0, out_valid=0, carry=0, in_ready=1. A subsequent ACC with B=0x0003 -> 0x0003.
